sdram_init_monitor: RTL

- Command-bus responder/checker for the SDRAM interface. It sits on the controller's SDRAM pins in place of the device, or alongside it.
- Decodes {cs_n, ras_n, cas_n, we_n}, addr and bank each cycle, and tracks the device-side power-up/initialisation protocol: power-up wait, PRECHARGE ALL, N auto-refreshes, LOAD MODE REGISTER.
- Reports completion, the programmed mode register, and the first protocol or timing violation.
- Used in simulation and on the FPGA bring-up build to qualify the init sequencer.

---
 rtl/sdram_init_monitor_if.sv | 10 +
 rtl/sdram_init_monitor.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sdram_init_monitor_if.sv
// SDRAM command bus as seen on the device pins: the controller drives it and
// the init monitor observes it.
interface sdram_init_monitor_if;
    logic [3:0]  cmd;   // {cs_n, ras_n, cas_n, we_n}
    logic [11:0] addr;
    logic [1:0]  bank;

    modport master (output cmd, addr, bank);
    modport slave  (input  cmd, addr, bank);
endinterface

// File: rtl/sdram_init_monitor.sv
// Device-side checker for the SDRAM power-up/initialisation protocol: power-up wait,
// PRECHARGE ALL, N_REF auto-refreshes, LOAD MODE; flags the first violation seen.
module sdram_init_monitor #(
    parameter int T_POWERUP = 10000,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int T_MRD     = 2,
    parameter int N_REF     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_init_monitor_if.slave  bus,
    output logic                 init_done,
    output logic                 init_err,
    output logic [2:0]           err_code,
    output logic [11:0]          mode_reg,
    output logic [3:0]           ref_cnt
);

    typedef enum logic [2:0] {PWR, TRP, TRFC, TMRD, DONE, ERR} state_t;
    typedef enum logic [2:0] {C_DESEL, C_NOP, C_PRE, C_REF, C_MRS, C_OTHER} cmd_t;

    // The timer holds (cycles since entry - 1) at each edge, so a command at
    // the T-th edge after entry is legal once timer >= T-1.
    localparam logic [15:0] PWR_LIM = 16'(T_POWERUP - 1);
    localparam logic [15:0] RP_LIM  = 16'(T_RP - 1);
    localparam logic [15:0] RFC_LIM = 16'(T_RFC - 1);
    localparam logic [15:0] MRD_LIM = 16'(T_MRD - 1);

    state_t      state, state_nx;
    cmd_t        cmd_dec;
    logic [15:0] timer;
    logic        active;
    logic        timer_clr;
    logic        err_set;
    logic [2:0]  code_nx;
    logic        ref_inc;
    logic        mode_cap;
    logic        cl_ok, bl_ok;
    logic        unused_bank;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign unused_bank = ^bus.bank;

    always_comb begin
        cmd_dec = C_OTHER;
        if (bus.cmd[3])              cmd_dec = C_DESEL;
        else if (bus.cmd == 4'b0111) cmd_dec = C_NOP;
        else if (bus.cmd == 4'b0010) cmd_dec = C_PRE;
        else if (bus.cmd == 4'b0001) cmd_dec = C_REF;
        else if (bus.cmd == 4'b0000) cmd_dec = C_MRS;
    end

    assign active = (cmd_dec != C_DESEL) && (cmd_dec != C_NOP);
    assign cl_ok  = (bus.addr[6:4] == 3'b010) || (bus.addr[6:4] == 3'b011);
    assign bl_ok  = (bus.addr[2] == 1'b0) || (bus.addr[2:0] == 3'b111);

    always_ff @(posedge clk) begin
        if (rst) state <= PWR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        timer_clr = 1'b0;
        err_set   = 1'b0;
        code_nx   = 3'd0;
        ref_inc   = 1'b0;
        mode_cap  = 1'b0;
        case (state)
            PWR: if (active) begin
                if (timer < PWR_LIM) begin
                    err_set = 1'b1; code_nx = 3'd1;
                end else if (cmd_dec == C_PRE && bus.addr[10]) begin
                    state_nx = TRP; timer_clr = 1'b1;
                end else if (cmd_dec == C_PRE) begin
                    err_set = 1'b1; code_nx = 3'd2;
                end else begin
                    err_set = 1'b1; code_nx = 3'd4;
                end
            end
            TRP: if (active) begin
                if (timer < RP_LIM) begin
                    err_set = 1'b1; code_nx = 3'd3;
                end else if (cmd_dec == C_REF) begin
                    state_nx = TRFC; timer_clr = 1'b1; ref_inc = 1'b1;
                end else begin
                    err_set = 1'b1; code_nx = 3'd4;
                end
            end
            TRFC: if (active) begin
                if (timer < RFC_LIM) begin
                    err_set = 1'b1; code_nx = 3'd3;
                end else if (cmd_dec == C_REF) begin
                    state_nx = TRFC; timer_clr = 1'b1; ref_inc = 1'b1;
                end else if (cmd_dec == C_MRS && int'(ref_cnt) >= N_REF) begin
                    mode_cap = 1'b1;
                    if (!cl_ok) begin
                        err_set = 1'b1; code_nx = 3'd5;
                    end else if (!bl_ok) begin
                        err_set = 1'b1; code_nx = 3'd6;
                    end else begin
                        state_nx = TMRD; timer_clr = 1'b1;
                    end
                end else begin
                    err_set = 1'b1; code_nx = 3'd4;
                end
            end
            TMRD: begin
                if (timer < MRD_LIM) begin
                    if (active) begin
                        err_set = 1'b1; code_nx = 3'd3;
                    end
                end else begin
                    state_nx = DONE;
                end
            end
            default: ;
        endcase
        if (err_set) state_nx = ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer     <= 16'd0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_code  <= 3'd0;
            mode_reg  <= 12'd0;
            ref_cnt   <= 4'd0;
        end else begin
            if (timer_clr)
                timer <= 16'd0;
            else if (state == PWR || state == TRP || state == TRFC || state == TMRD)
                timer <= sat_inc16(timer);
            if (ref_inc)  ref_cnt  <= sat_inc4(ref_cnt);
            if (mode_cap) mode_reg <= bus.addr;
            if (err_set) begin
                init_err <= 1'b1;
                err_code <= code_nx;
            end
            if (state == TMRD && state_nx == DONE) init_done <= 1'b1;
        end
    end

endmodule
